// File: rtl/lfsr_seq_ctrl_if.sv
// Command and output-stream handshake bundle for lfsr_seq_ctrl.
// master issues commands and consumes generated values; slave is the controller.
interface lfsr_seq_ctrl_if #(
   parameter int W  = 16,
   parameter int CW = 20
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [1:0]    cmd_op;
   logic [W-1:0]  cmd_seed;
   logic [CW-1:0] cmd_count;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;

   modport master (
      output cmd_valid, cmd_op, cmd_seed, cmd_count, out_ready,
      input  cmd_ready, out_valid, out_data
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_seed, cmd_count, out_ready,
      output cmd_ready, out_valid, out_data
   );
endinterface

// File: rtl/lfsr_seq_ctrl.sv
// Command-driven sequencer owning the LFSR state register: LOAD, STEP_N and
// PERIOD commands, streamed output values and measured sequence period.
module lfsr_seq_ctrl #(
   parameter int           W            = 16,
   parameter int           CW           = 20,
   parameter logic [W-1:0] SEED_DEFAULT = 16'h01ab
) (
   input  logic           clk,
   input  logic           reset,
   lfsr_seq_ctrl_if.slave bus,
   input  logic           abort,
   output logic [W-1:0]   lfsr_cur,
   input  logic [W-1:0]   lfsr_nxt,
   output logic           done,
   output logic [CW-1:0]  period,
   output logic           err_zero,
   output logic           err_timeout
);
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN_N   = 2'd1,
      RUN_PER = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam logic [1:0]    OP_LOAD   = 2'd0;
   localparam logic [1:0]    OP_STEP   = 2'd1;
   localparam logic [1:0]    OP_PERIOD = 2'd2;
   localparam logic [W-1:0]  ZERO_W    = {W{1'b0}};
   localparam logic [CW-1:0] ZERO_CW   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] CNT_LIMIT = {CW{1'b1}};

   state_t        state_q, state_d;
   logic [W-1:0]  lfsr_q, lfsr_d;
   logic [W-1:0]  start_q, start_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] target_q, target_d;
   logic [CW-1:0] period_q, period_d;
   logic          cmd_ready_q, cmd_ready_d;
   logic          out_valid_q, out_valid_d;
   logic          done_q, done_d;
   logic          err_zero_q, err_zero_d;
   logic          err_timeout_q, err_timeout_d;
   logic [CW-1:0] cnt_inc;
   logic          step;

   // Next-state and next-output computation for the command sequencer.
   always_comb begin
      state_d       = state_q;
      lfsr_d        = lfsr_q;
      start_d       = start_q;
      cnt_d         = cnt_q;
      target_d      = target_q;
      period_d      = period_q;
      err_zero_d    = 1'b0;
      err_timeout_d = 1'b0;
      cnt_inc       = cnt_q + CNT_ONE;
      // abort suppresses the step even when the consumer is ready
      step          = out_valid_q & bus.out_ready & ~abort;
      case (state_q)
         IDLE: begin
            if (bus.cmd_valid) begin
               state_d = DONE;
               case (bus.cmd_op)
                  OP_LOAD: begin
                     if (bus.cmd_seed != ZERO_W) lfsr_d = bus.cmd_seed;
                     else                         err_zero_d = 1'b1;
                  end
                  OP_STEP: begin
                     if (bus.cmd_count == ZERO_CW) begin
                        state_d = DONE;
                     end else if (lfsr_q == ZERO_W) begin
                        err_zero_d = 1'b1;
                     end else begin
                        cnt_d    = ZERO_CW;
                        target_d = bus.cmd_count;
                        state_d  = RUN_N;
                     end
                  end
                  OP_PERIOD: begin
                     if (lfsr_q == ZERO_W) begin
                        err_zero_d = 1'b1;
                     end else begin
                        start_d = lfsr_q;
                        cnt_d   = ZERO_CW;
                        state_d = RUN_PER;
                     end
                  end
                  default: state_d = DONE;
               endcase
            end else begin
               state_d = IDLE;
            end
         end
         RUN_N: begin
            if (abort) begin
               state_d = DONE;
            end else if (step) begin
               lfsr_d = lfsr_nxt;
               cnt_d  = cnt_inc;
               if (cnt_inc == target_q) state_d = DONE;
               else                     state_d = RUN_N;
            end else begin
               state_d = RUN_N;
            end
         end
         RUN_PER: begin
            if (abort) begin
               state_d = DONE;
            end else if (step) begin
               lfsr_d = lfsr_nxt;
               cnt_d  = cnt_inc;
               // a repeat wins over the timeout on the same step
               if (lfsr_nxt == start_q) begin
                  period_d = cnt_inc;
                  state_d  = DONE;
               end else if (cnt_inc == CNT_LIMIT) begin
                  period_d      = ZERO_CW;
                  err_timeout_d = 1'b1;
                  state_d       = DONE;
               end else begin
                  state_d = RUN_PER;
               end
            end else begin
               state_d = RUN_PER;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      cmd_ready_d = (state_d == IDLE);
      out_valid_d = (state_d == RUN_N) || (state_d == RUN_PER);
      done_d      = (state_d == DONE);
   end

   // State and registered-output flops with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q       <= IDLE;
         lfsr_q        <= SEED_DEFAULT;
         start_q       <= ZERO_W;
         cnt_q         <= ZERO_CW;
         target_q      <= ZERO_CW;
         period_q      <= ZERO_CW;
         cmd_ready_q   <= 1'b1;
         out_valid_q   <= 1'b0;
         done_q        <= 1'b0;
         err_zero_q    <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         lfsr_q        <= lfsr_d;
         start_q       <= start_d;
         cnt_q         <= cnt_d;
         target_q      <= target_d;
         period_q      <= period_d;
         cmd_ready_q   <= cmd_ready_d;
         out_valid_q   <= out_valid_d;
         done_q        <= done_d;
         err_zero_q    <= err_zero_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign bus.cmd_ready = cmd_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = lfsr_nxt;
   assign lfsr_cur      = lfsr_q;
   assign done          = done_q;
   assign period        = period_q;
   assign err_zero      = err_zero_q;
   assign err_timeout   = err_timeout_q;
endmodule

// File: tb/tb_lfsr_seq_ctrl.sv
// Bench for lfsr_seq_ctrl: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, plus a random phase.
module tb_lfsr_seq_ctrl;
   localparam int W  = 16;
   localparam int CW = 20;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          abort = 1'b0;
   logic          stuck = 1'b0;
   logic [W-1:0]  lfsr_cur, lfsr_nxt;
   logic          done, err_zero, err_timeout;
   logic [CW-1:0] period;

   int n_cmp = 0;
   int n_bad = 0;

   lfsr_seq_ctrl_if #(.W(W), .CW(CW)) bus ();

   lfsr_seq_ctrl #(.W(W), .CW(CW), .SEED_DEFAULT(16'h01ab)) dut (
      .clk(clk), .reset(reset), .bus(bus), .abort(abort),
      .lfsr_cur(lfsr_cur), .lfsr_nxt(lfsr_nxt), .done(done),
      .period(period), .err_zero(err_zero), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   // Maximal-length 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), optionally stuck at zero.
   function automatic logic [W-1:0] lfsr_f(input logic [W-1:0] s);
      return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
   endfunction
   function automatic logic [W-1:0] mf(input logic [W-1:0] s);
      return stuck ? 16'h0000 : lfsr_f(s);
   endfunction
   assign lfsr_nxt = stuck ? 16'h0000 : lfsr_f(lfsr_cur);

   // Reference model: what the controller must show after each edge.
   bit            m_on = 1'b0;
   bit            m_idle, m_done, m_ez, m_et;
   int            m_run;   // 0 none, 1 step run, 2 period run
   int            m_left, m_steps;
   logic [W-1:0]  m_cur, m_start;
   logic [CW-1:0] m_period;
   logic [W-1:0]  got[$];

   always @(posedge clk) begin
      logic [W-1:0] nx;
      if (!reset) begin
         m_on = 1'b1; m_cur = 16'h01ab; m_period = '0; m_run = 0;
         m_idle = 1'b1; m_done = 1'b0; m_ez = 1'b0; m_et = 1'b0;
      end else if (m_on) begin
         if (m_done) begin
            m_done = 1'b0; m_ez = 1'b0; m_et = 1'b0; m_idle = 1'b1;
         end else if (m_idle) begin
            if (bus.cmd_valid) begin
               m_idle = 1'b0; m_done = 1'b1;
               if (bus.cmd_op == 2'd0) begin
                  if (bus.cmd_seed != 16'h0000) m_cur = bus.cmd_seed;
                  else m_ez = 1'b1;
               end else if (bus.cmd_op == 2'd1 && bus.cmd_count != '0) begin
                  if (m_cur == 16'h0000) m_ez = 1'b1;
                  else begin m_run = 1; m_left = int'(bus.cmd_count); m_done = 1'b0; end
               end else if (bus.cmd_op == 2'd2) begin
                  if (m_cur == 16'h0000) m_ez = 1'b1;
                  else begin m_run = 2; m_start = m_cur; m_steps = 0; m_done = 1'b0; end
               end
            end
         end else if (m_run != 0) begin
            if (abort) begin
               m_run = 0; m_done = 1'b1;
            end else if (bus.out_ready) begin
               nx = mf(m_cur);
               m_cur = nx;
               if (m_run == 1) begin
                  m_left--;
                  if (m_left == 0) begin m_run = 0; m_done = 1'b1; end
               end else begin
                  m_steps++;
                  if (nx == m_start) begin
                     m_period = CW'(m_steps); m_run = 0; m_done = 1'b1;
                  end else if (m_steps == 2**CW - 1) begin
                     m_period = '0; m_et = 1'b1; m_run = 0; m_done = 1'b1;
                  end
               end
            end
         end
      end
   end

   // Consumer: records every transferred value.
   always @(posedge clk) begin
      if (reset && bus.out_valid && bus.out_ready && !abort) got.push_back(bus.out_data);
   end

   task automatic finish_run();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   // Per-cycle comparison of all outputs against the model.
   always @(negedge clk) begin
      logic [W-1:0] exp_data, act_data;
      if (m_on) begin
         exp_data = (m_run != 0) ? mf(m_cur) : 16'h0000;
         act_data = (m_run != 0) ? bus.out_data : 16'h0000;
         n_cmp++;
         if (lfsr_cur !== m_cur || bus.cmd_ready !== m_idle || bus.out_valid !== (m_run != 0) ||
             act_data !== exp_data || done !== m_done || err_zero !== m_ez ||
             err_timeout !== m_et || period !== m_period) begin
            n_bad++;
            $display("FAIL per_cycle t=%0t got cur=%h rdy=%b vld=%b data=%h done=%b ez=%b et=%b per=%0d want cur=%h rdy=%b vld=%b data=%h done=%b ez=%b et=%b per=%0d",
                     $time, lfsr_cur, bus.cmd_ready, bus.out_valid, act_data, done, err_zero, err_timeout, period,
                     m_cur, m_idle, (m_run != 0), exp_data, m_done, m_ez, m_et, m_period);
            if (n_bad > 200) begin
               $display("FAIL too_many_mismatches got %0d allowed 200", n_bad);
               finish_run();
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic send_cmd(input logic [1:0] op, input logic [W-1:0] seed, input logic [CW-1:0] cnt);
      int i = 0;
      while (!bus.cmd_ready && i < 50) begin @(negedge clk); i++; end
      if (!bus.cmd_ready) check("cmd_ready_wait", {31'd0, bus.cmd_ready}, 32'd1);
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_seed = seed; bus.cmd_count = cnt;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
   endtask

   // mode 0: ready held high, 1: ready toggles every cycle, 2: random ready
   task automatic run_until_done(input int budget, input int mode, input string name);
      int i = 0;
      while (!done && i < budget) begin
         if (mode == 0) bus.out_ready = 1'b1;
         else if (mode == 1) bus.out_ready = ~bus.out_ready;
         else bus.out_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         i++;
      end
      check(name, {31'd0, done}, 32'd1);
   endtask

   task automatic check_ref(input logic [W-1:0] seed, input int k, input string name);
      logic [W-1:0] s = seed;
      check({name, "_count"}, got.size(), k);
      for (int i = 0; i < k && i < got.size(); i++) begin
         s = lfsr_f(s);
         check(name, got[i], s);
      end
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: time limit reached at %0t", $time);
      finish_run();
   end

   initial begin
      int idx;
      logic [1:0] op;
      bus.cmd_valid = 1'b0; bus.cmd_op = 2'd0; bus.cmd_seed = '0; bus.cmd_count = '0;
      bus.out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_cur", lfsr_cur, 16'h01ab);
      check("rst_ready", bus.cmd_ready, 1);
      check("rst_valid", bus.out_valid, 0);
      check("rst_period", period, 0);
      reset = 1'b1;
      @(negedge clk);

      send_cmd(2'd0, 16'hACE1, '0);
      check("load_cur", lfsr_cur, 16'hACE1);
      check("load_done", done, 1);
      @(negedge clk);
      check("load_done_once", done, 0);

      send_cmd(2'd0, 16'h0000, '0);
      check("load0_ez", err_zero, 1);
      check("load0_done", done, 1);
      check("load0_cur", lfsr_cur, 16'hACE1);

      got.delete();
      send_cmd(2'd1, '0, 20'd1);
      run_until_done(20, 0, "step1_done");
      check("step1_cur", lfsr_cur, 16'h5670);
      check("step1_val", got.size() > 0 ? got[0] : 16'hxxxx, 16'h5670);

      send_cmd(2'd0, 16'h01ab, '0);
      got.delete();
      send_cmd(2'd1, '0, 20'd5);
      run_until_done(40, 0, "step5_done");
      check_ref(16'h01ab, 5, "step5");

      send_cmd(2'd0, 16'h01ab, '0);
      got.delete();
      send_cmd(2'd1, '0, 20'd5);
      run_until_done(40, 1, "step5t_done");
      check_ref(16'h01ab, 5, "step5t");

      @(negedge clk);
      got.delete();
      send_cmd(2'd1, '0, 20'd0);
      check("step0_done", done, 1);
      check("step0_valid", bus.out_valid, 0);
      check("step0_none", got.size(), 0);

      send_cmd(2'd0, 16'h01ab, '0);
      got.delete();
      bus.out_ready = 1'b1;
      send_cmd(2'd1, '0, 20'd100);
      idx = 0;
      while (got.size() < 10 && idx < 60) begin @(negedge clk); idx++; end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_done", done, 1);
      check_ref(16'h01ab, 10, "abort");
      check("abort_cur", lfsr_cur, got.size() >= 10 ? got[9] : 16'hxxxx);
      @(negedge clk);
      check("abort_ready", bus.cmd_ready, 1);

      stuck = 1'b1;
      send_cmd(2'd1, '0, 20'd1);
      run_until_done(20, 0, "stuck_step_done");
      check("stuck_cur", lfsr_cur, 16'h0000);
      @(negedge clk);
      send_cmd(2'd2, '0, '0);
      check("per0_ez", err_zero, 1);
      check("per0_done", done, 1);
      send_cmd(2'd1, '0, 20'd3);
      check("step_zero_ez", err_zero, 1);
      stuck = 1'b0;
      send_cmd(2'd0, 16'h01ab, '0);

      send_cmd(2'd0, 16'hACE1, '0);
      send_cmd(2'd1, '0, 20'd50);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      check("mrst_cur", lfsr_cur, 16'h01ab);
      check("mrst_ready", bus.cmd_ready, 1);
      check("mrst_valid", bus.out_valid, 0);
      check("mrst_done", done, 0);

      for (int c = 0; c < 400; c++) begin
         idx = $urandom_range(0, 2);
         op = (idx == 2) ? 2'd3 : 2'(idx);
         bus.cmd_valid = 1'($urandom_range(0, 1));
         bus.cmd_op = op;
         bus.cmd_seed = ($urandom_range(0, 7) == 0) ? 16'h0000 : W'($urandom);
         bus.cmd_count = CW'($urandom_range(0, 11));
         bus.out_ready = 1'($urandom_range(0, 1));
         abort = ($urandom_range(0, 15) == 0);
         @(negedge clk);
      end
      bus.cmd_valid = 1'b0; abort = 1'b0; bus.out_ready = 1'b1;
      idx = 0;
      while (!bus.cmd_ready && idx < 40) begin @(negedge clk); idx++; end
      check("rand_idle", bus.cmd_ready, 1);

      send_cmd(2'd0, 16'h01ab, '0);
      send_cmd(2'd2, '0, '0);
      run_until_done(70000, 0, "period_done");
      check("period_val", period, 20'd65535);
      check("period_et", err_timeout, 0);
      check("period_cur", lfsr_cur, 16'h01ab);
      @(negedge clk);
      check("period_hold", period, 20'd65535);

      finish_run();
   end
endmodule
